// File: rtl/matrix_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_pkg
//  Description : Shared types and constants for the 8x8 LED matrix scan
//                controller: scan FSM state encoding, frame buffer type,
//                matrix geometry and the tick counter width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package matrix_pkg;

  localparam int MATRIX_ROWS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } scan_state_t;

  // frame[r][c] : row r, column c, 1 = LED on
  typedef logic [7:0][7:0] frame_t;

  // Counter width able to hold 0 .. max(a,b)-1, never narrower than 1 bit.
  function automatic int tick_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_scan_ctrl_if
//  Description : Control/data bundle of the matrix scan controller.
//                master : drives en, load, frame_in; observes the outputs
//                slave  : the controller itself
//  Signals     : en, load, frame_in[7:0][7:0]  (master -> slave)
//                row_sel[7:0], col_data[7:0], frame_done, pending
//                                               (slave -> master)
//  Revision    : 1.0  initial release
// ============================================================================
interface matrix_scan_ctrl_if;
  import matrix_pkg::*;

  logic       en;
  logic       load;
  frame_t     frame_in;
  logic [7:0] row_sel;
  logic [7:0] col_data;
  logic       frame_done;
  logic       pending;

  modport master (
    output en, load, frame_in,
    input  row_sel, col_data, frame_done, pending
  );

  modport slave (
    input  en, load, frame_in,
    output row_sel, col_data, frame_done, pending
  );

endinterface
`default_nettype wire

// File: rtl/matrix_scan_ctrl_scan_timer.sv
`default_nettype none
// ============================================================================
//  Module      : scan_timer
//  Description : Tick counter for the scan FSM. Counts up every cycle unless
//                clear forces it back to zero; tc flags count == limit.
//  Ports       : clk, reset (async, active-high)
//                clear  - load zero on the next edge
//                limit  - terminal count value
//                tc     - terminal count reached (decoded from the register)
//  Revision    : 1.0  initial release
// ============================================================================
module scan_timer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] limit,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      count <= count + WIDTH'(1);
    end
  end

  assign tc = (count == limit);

endmodule
`default_nettype wire

// File: rtl/matrix_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_scan_ctrl
//  Description : Double-buffered 8x8 LED matrix row scanner. Each row is
//                driven for ROW_TICKS cycles followed by BLANK_TICKS cycles
//                of all-off blanking. New frames land in a pending buffer and
//                are only swapped into the displayed buffer at frame
//                boundaries, so a frame is never shown half old / half new.
//  Ports       : clk, reset (async, active-high)
//                bus (slave) : en, load, frame_in -> row_sel, col_data,
//                              frame_done, pending
//  Revision    : 1.0  initial release
// ============================================================================
module matrix_scan_ctrl
  import matrix_pkg::*;
#(
  parameter int ROW_TICKS   = 50000,
  parameter int BLANK_TICKS = 500
) (
  input  logic               clk,
  input  logic               reset,
  matrix_scan_ctrl_if.slave  bus
);

  if (ROW_TICKS < 1 || BLANK_TICKS < 1) begin : g_param_check
    $error("matrix_scan_ctrl: ROW_TICKS and BLANK_TICKS must both be >= 1");
  end

  localparam int         TICK_W   = tick_width(ROW_TICKS, BLANK_TICKS);
  localparam logic [2:0] LAST_ROW = 3'(MATRIX_ROWS - 1);

  scan_state_t       state, state_n;
  logic [2:0]        row_idx, row_idx_n;
  frame_t            active_buf;
  frame_t            pending_buf;
  logic              pending_flag;
  logic              swap;
  logic              tc;
  logic              tick_clear;
  logic [TICK_W-1:0] tick_limit;

  // The timer restarts from zero on every state change and stays parked at
  // zero while idle, so each phase always starts at tick 0.
  assign tick_limit = (state == SHOW) ? TICK_W'(ROW_TICKS - 1)
                                      : TICK_W'(BLANK_TICKS - 1);
  assign tick_clear = (state == IDLE) || !bus.en || tc;

  scan_timer #(
    .WIDTH (TICK_W)
  ) u_scan_timer (
    .clk   (clk),
    .reset (reset),
    .clear (tick_clear),
    .limit (tick_limit),
    .tc    (tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      row_idx <= '0;
    end else begin
      state   <= state_n;
      row_idx <= row_idx_n;
    end
  end

  // Next state; swap is only ever raised on the two frame-boundary edges.
  always_comb begin
    state_n   = state;
    row_idx_n = row_idx;
    swap      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.en) begin
          state_n   = SHOW;
          row_idx_n = '0;
          swap      = pending_flag;
        end
      end
      SHOW: begin
        if (!bus.en) begin
          state_n   = IDLE;
          row_idx_n = '0;
        end else if (tc) begin
          state_n = BLANK;
        end
      end
      BLANK: begin
        if (!bus.en) begin
          state_n   = IDLE;
          row_idx_n = '0;
        end else if (tc) begin
          state_n = SHOW;
          if (row_idx == LAST_ROW) begin
            row_idx_n = '0;
            swap      = pending_flag;
          end else begin
            row_idx_n = row_idx + 3'd1;
          end
        end
      end
      default: begin
        state_n   = IDLE;
        row_idx_n = '0;
      end
    endcase
  end

  // A load on the swap edge is safe: active takes the old pending contents
  // while pending takes the new frame, and the flag stays set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_buf   <= '0;
      pending_buf  <= '0;
      pending_flag <= 1'b0;
    end else begin
      if (swap) begin
        active_buf <= pending_buf;
      end
      if (bus.load) begin
        pending_buf  <= bus.frame_in;
        pending_flag <= 1'b1;
      end else if (swap) begin
        pending_flag <= 1'b0;
      end
    end
  end

  // Outputs depend on registers only (state, row_idx, timer, buffers).
  always_comb begin
    bus.row_sel    = '0;
    bus.col_data   = '0;
    if (state == SHOW) begin
      bus.row_sel  = 8'h01 << row_idx;
      bus.col_data = active_buf[row_idx];
    end
    bus.frame_done = (state == BLANK) && (row_idx == LAST_ROW) && tc;
    bus.pending    = pending_flag;
  end

endmodule
`default_nettype wire

// File: tb/tb_matrix_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matrix_scan_ctrl
//  Description : Self-checking bench for matrix_scan_ctrl (ROW_TICKS=4,
//                BLANK_TICKS=2). A frame-position model predicts every output
//                each cycle; directed scenarios pin literal values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_matrix_scan_ctrl;
  import matrix_pkg::*;

  localparam int R     = 4;
  localparam int B     = 2;
  localparam int SLOT  = R + B;
  localparam int FRAME = 8 * SLOT;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  matrix_scan_ctrl_if bus();

  matrix_scan_ctrl #(
    .ROW_TICKS   (R),
    .BLANK_TICKS (B)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model: position within the frame ----------
  bit     m_run;
  int     m_pos;
  frame_t m_active, m_pbuf;
  bit     m_pflag;

  always @(posedge clk or posedge reset) begin
    bit sw;
    if (reset) begin
      m_run = 0; m_pos = 0; m_active = '0; m_pbuf = '0; m_pflag = 0;
    end else begin
      sw = 0;
      if (!m_run) begin
        if (bus.en) begin m_run = 1; m_pos = 0; sw = m_pflag; end
      end else if (!bus.en) begin
        m_run = 0; m_pos = 0;
      end else begin
        m_pos++;
        if (m_pos == FRAME) begin m_pos = 0; sw = m_pflag; end
      end
      if (sw) begin m_active = m_pbuf; m_pflag = 0; end
      if (bus.load) begin m_pbuf = bus.frame_in; m_pflag = 1; end
    end
  end

  always @(negedge clk) begin
    logic [7:0] e_rs, e_cd;
    logic       e_fd;
    int         row, ph;
    row  = m_pos / SLOT;
    ph   = m_pos % SLOT;
    e_rs = 8'h00;
    e_cd = 8'h00;
    if (m_run && ph < R) begin
      e_rs = 8'h01 << row;
      e_cd = m_active[row];
    end
    e_fd = m_run && (m_pos == FRAME - 1);
    chk("model row_sel",    bus.row_sel,    e_rs);
    chk("model col_data",   bus.col_data,   e_cd);
    chk("model frame_done", bus.frame_done, e_fd);
    chk("model pending",    bus.pending,    m_pflag);
  end

  // ---------------- stimulus ----------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [7:0] v);
    for (int r = 0; r < 8; r++) bus.frame_in[r] = v;
  endtask

  initial begin
    int fd_count;
    reset = 1'b1;
    bus.en = 1'b0;
    bus.load = 1'b0;
    bus.frame_in = '0;
    repeat (3) step();
    chk("reset row_sel",    bus.row_sel,    8'h00);
    chk("reset col_data",   bus.col_data,   8'h00);
    chk("reset frame_done", bus.frame_done, 1'b0);
    chk("reset pending",    bus.pending,    1'b0);
    reset = 1'b0;
    step();

    // Asynchronous reset in the middle of BLANK with a frame pending.
    fill(8'h55); bus.load = 1'b1; step();
    bus.load = 1'b0; bus.en = 1'b1; step();          // SHOW row 0
    chk("pre-reset col_data", bus.col_data, 8'h55);
    fill(8'h33); bus.load = 1'b1; step();
    bus.load = 1'b0;
    repeat (3) step();                               // BLANK row 0
    chk("pre-reset pending", bus.pending, 1'b1);
    chk("pre-reset blank",   bus.row_sel, 8'h00);
    #2;
    reset = 1'b1;
    bus.en = 1'b0;
    #1;
    chk("async reset row_sel",    bus.row_sel,    8'h00);
    chk("async reset col_data",   bus.col_data,   8'h00);
    chk("async reset frame_done", bus.frame_done, 1'b0);
    chk("async reset pending",    bus.pending,    1'b0);
    step();
    reset = 1'b0;
    bus.en = 1'b1;
    step();
    chk("post-reset row_sel",  bus.row_sel,  8'h01);
    chk("post-reset col_data", bus.col_data, 8'h00);
    bus.en = 1'b0;
    repeat (2) step();

    // First frame A: row r lights column r.
    for (int r = 0; r < 8; r++) bus.frame_in[r] = 8'h01 << r;
    bus.load = 1'b1; step();
    bus.load = 1'b0;
    chk("idle pending", bus.pending, 1'b1);
    chk("idle row_sel", bus.row_sel, 8'h00);
    bus.en = 1'b1;
    step();
    fd_count = 0;
    for (int c = 0; c < 132; c++) begin
      if (c < 48 && bus.frame_done) fd_count++;
      if (c == 0) begin
        chk("row0 row_sel", bus.row_sel, 8'h01);
        chk("row0 col_data", bus.col_data, 8'h01);
        chk("swap clears pending", bus.pending, 1'b0);
      end
      if (c == 3) chk("row0 last show", bus.row_sel, 8'h01);
      if (c == 4 || c == 5) begin
        chk("row0 blank row_sel", bus.row_sel, 8'h00);
        chk("row0 blank col_data", bus.col_data, 8'h00);
      end
      if (c == 6) begin
        chk("row1 row_sel", bus.row_sel, 8'h02);
        chk("row1 col_data", bus.col_data, 8'h02);
        chk("row1 pending", bus.pending, 1'b0);
      end
      if (c == 24) begin
        chk("row4 keeps A", bus.col_data, 8'h10);
        chk("B pending row4", bus.pending, 1'b1);
      end
      if (c == 42) begin
        chk("row7 row_sel", bus.row_sel, 8'h80);
        chk("row7 keeps A", bus.col_data, 8'h80);
      end
      if (c == 47) chk("frame_done at wrap", bus.frame_done, 1'b1);
      if (c == 48) begin
        chk("frame_done count", fd_count, 1);
        chk("wrap row_sel", bus.row_sel, 8'h01);
        chk("frame B shown", bus.col_data, 8'hFF);
        chk("coincident pending", bus.pending, 1'b1);
        chk("frame_done low after", bus.frame_done, 1'b0);
      end
      if (c == 95) chk("frame_done frame2", bus.frame_done, 1'b1);
      if (c == 96) begin
        chk("frame C shown", bus.col_data, 8'hAA);
        chk("C swapped pending", bus.pending, 1'b0);
      end
      if (c == 128) begin
        chk("disable row_sel", bus.row_sel, 8'h00);
        chk("disable frame_done", bus.frame_done, 1'b0);
      end
      if (c == 131) begin
        chk("re-enable row_sel", bus.row_sel, 8'h01);
        chk("re-enable col_data", bus.col_data, 8'hAA);
      end
      // inputs for the next edge
      bus.load = 1'b0;
      if (c == 19) begin fill(8'hFF); bus.load = 1'b1; end  // row 3
      if (c == 47) begin fill(8'hAA); bus.load = 1'b1; end  // frame_done edge
      if (c == 127) bus.en = 1'b0;                           // row 5 SHOW
      if (c == 130) bus.en = 1'b1;
      step();
    end

    // Randomized phase against the model.
    for (int i = 0; i < 3000; i++) begin
      bus.en   = ($urandom_range(0, 99) < 97);
      bus.load = ($urandom_range(0, 99) < 6);
      for (int r = 0; r < 8; r++) bus.frame_in[r] = 8'($urandom);
      reset = ($urandom_range(0, 599) == 0);
      step();
      if (reset && $urandom_range(0, 1) == 1) begin
        reset = 1'b0;
        step();
      end
    end
    reset = 1'b0;
    bus.en = 1'b0;
    bus.load = 1'b0;
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
